// File: rtl/morse_char_decoder.sv
// Morse character decoder: re-samples the symbol stream from the divided-clock
// symbol FSM, accumulates dots/dashes and emits one ASCII byte per character
// on a valid/ready port toward the LCD write controller.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no symbols collected, sym_count == 0; end-of-char is ignored
// ST_ACCUM | 1..MAX_SYMS symbols collected, end-of-char triggers a lookup
// ST_OVF   | too many symbols; further marks ignored, end emits UNKNOWN_CHAR
module morse_char_decoder #(
    parameter int unsigned MAX_SYMS     = 5,
    parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sym,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       char_drop,
    output logic [2:0] sym_count
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_SYMS);

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_END  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OVF   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] sym_q1;
    logic [1:0] sym_q2;
    logic [1:0] last_sym;
    logic [6:0] pattern;
    logic [6:0] pattern_nxt;
    logic [2:0] count_nxt;
    logic       lut_load;
    logic [7:0] lut_byte;
    logic [7:0] lut_q;
    logic       lut_vld;
    logic       sym_stable;
    logic       sym_evt;
    logic       evt_mark;
    logic       evt_end;

    // ITU Morse lookup; pattern holds the symbols MSB-first, dot=0, dash=1.
    // Upper pattern bits are always zero because the accumulator clears them.
    function automatic logic [7:0] morse_lookup(input logic [2:0] len,
                                                input logic [6:0] pat);
        logic [7:0] ch;
        case ({len, pat})
            {3'd1, 7'h00}: ch = 8'h45; // E
            {3'd1, 7'h01}: ch = 8'h54; // T
            {3'd2, 7'h00}: ch = 8'h49; // I
            {3'd2, 7'h01}: ch = 8'h41; // A
            {3'd2, 7'h02}: ch = 8'h4E; // N
            {3'd2, 7'h03}: ch = 8'h4D; // M
            {3'd3, 7'h00}: ch = 8'h53; // S
            {3'd3, 7'h01}: ch = 8'h55; // U
            {3'd3, 7'h02}: ch = 8'h52; // R
            {3'd3, 7'h03}: ch = 8'h57; // W
            {3'd3, 7'h04}: ch = 8'h44; // D
            {3'd3, 7'h05}: ch = 8'h4B; // K
            {3'd3, 7'h06}: ch = 8'h47; // G
            {3'd3, 7'h07}: ch = 8'h4F; // O
            {3'd4, 7'h00}: ch = 8'h48; // H
            {3'd4, 7'h01}: ch = 8'h56; // V
            {3'd4, 7'h02}: ch = 8'h46; // F
            {3'd4, 7'h04}: ch = 8'h4C; // L
            {3'd4, 7'h06}: ch = 8'h50; // P
            {3'd4, 7'h07}: ch = 8'h4A; // J
            {3'd4, 7'h08}: ch = 8'h42; // B
            {3'd4, 7'h09}: ch = 8'h58; // X
            {3'd4, 7'h0A}: ch = 8'h43; // C
            {3'd4, 7'h0B}: ch = 8'h59; // Y
            {3'd4, 7'h0C}: ch = 8'h5A; // Z
            {3'd4, 7'h0D}: ch = 8'h51; // Q
            {3'd5, 7'h1F}: ch = 8'h30; // 0
            {3'd5, 7'h0F}: ch = 8'h31; // 1
            {3'd5, 7'h07}: ch = 8'h32; // 2
            {3'd5, 7'h03}: ch = 8'h33; // 3
            {3'd5, 7'h01}: ch = 8'h34; // 4
            {3'd5, 7'h00}: ch = 8'h35; // 5
            {3'd5, 7'h10}: ch = 8'h36; // 6
            {3'd5, 7'h18}: ch = 8'h37; // 7
            {3'd5, 7'h1C}: ch = 8'h38; // 8
            {3'd5, 7'h1E}: ch = 8'h39; // 9
            default:       ch = UNKNOWN_CHAR;
        endcase
        return ch;
    endfunction

    // A symbol is taken once it has been seen on two consecutive samples and
    // differs from the last stable value; idle (00) only re-arms detection.
    assign sym_stable = (sym_q1 == sym_q2);
    assign sym_evt    = sym_stable && (sym_q2 != last_sym) && (sym_q2 != SYM_NONE);
    assign evt_mark   = sym_evt && ((sym_q2 == SYM_DOT) || (sym_q2 == SYM_DASH));
    assign evt_end    = sym_evt && (sym_q2 == SYM_END);

    // Re-sample the divided-clock symbol code and track the last stable value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sym_q1   <= SYM_NONE;
            sym_q2   <= SYM_NONE;
            last_sym <= SYM_NONE;
        end else begin
            sym_q1 <= sym;
            sym_q2 <= sym_q1;
            if (sym_stable) begin
                last_sym <= sym_q2;
            end
        end
    end

    // Accumulator state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (evt_mark) begin
                    state_nxt = (sym_count == MAX_CNT) ? ST_OVF : ST_ACCUM;
                end else if (evt_end && (state == ST_ACCUM)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OVF: begin
                if (evt_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Accumulator datapath controls and lookup request.
    always_comb begin
        pattern_nxt = pattern;
        count_nxt   = sym_count;
        lut_load    = 1'b0;
        lut_byte    = UNKNOWN_CHAR;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (evt_mark && (sym_count != MAX_CNT)) begin
                    pattern_nxt = {pattern[5:0], sym_q2[1]};
                    count_nxt   = sym_count + 3'd1;
                end else if (evt_end && (state == ST_ACCUM)) begin
                    lut_load    = 1'b1;
                    lut_byte    = morse_lookup(sym_count, pattern);
                    pattern_nxt = 7'd0;
                    count_nxt   = 3'd0;
                end
            end
            ST_OVF: begin
                if (evt_end) begin
                    lut_load    = 1'b1;
                    lut_byte    = UNKNOWN_CHAR;
                    pattern_nxt = 7'd0;
                    count_nxt   = 3'd0;
                end
            end
            default: begin
                pattern_nxt = 7'd0;
                count_nxt   = 3'd0;
            end
        endcase
    end

    // Accumulator registers plus the one-deep lookup result stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern   <= 7'd0;
            sym_count <= 3'd0;
            lut_q     <= 8'h00;
            lut_vld   <= 1'b0;
        end else begin
            pattern   <= pattern_nxt;
            sym_count <= count_nxt;
            lut_vld   <= lut_load;
            if (lut_load) begin
                lut_q <= lut_byte;
            end
        end
    end

    // Output register: load when empty or draining, otherwise drop and flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            char_data  <= 8'h00;
            char_valid <= 1'b0;
            char_drop  <= 1'b0;
        end else begin
            char_drop <= 1'b0;
            if (lut_vld) begin
                if (!char_valid || char_ready) begin
                    char_data  <= lut_q;
                    char_valid <= 1'b1;
                end else begin
                    char_drop <= 1'b1;
                end
            end else if (char_valid && char_ready) begin
                char_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_char_decoder.sv
// Directed bench for morse_char_decoder: drives symbol sequences, collects
// accepted bytes and drop pulses, and compares against hand-computed values.
module tb_morse_char_decoder;

    logic       clk;
    logic       rst;
    logic [1:0] sym;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       char_drop;
    logic [2:0] sym_count;

    int n_checks = 0;
    int n_err    = 0;
    int drop_cnt = 0;
    int rd_idx   = 0;
    int drop_base;
    logic [7:0] got_q[$];

    morse_char_decoder #(
        .MAX_SYMS    (5),
        .UNKNOWN_CHAR(8'h3F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym       (sym),
        .char_data (char_data),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .char_drop (char_drop),
        .sym_count (sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record accepted bytes and drop pulses on the falling edge.
    always @(negedge clk) begin
        if (rst && char_valid && char_ready) got_q.push_back(char_data);
        if (rst && char_drop) drop_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] code, input int hold);
        sym = code;
        tick(hold);
    endtask

    // Send len marks MSB-first (bit 1 = dash), each followed by idle.
    task automatic send_syms(input int len, input logic [6:0] bits);
        for (int i = len - 1; i >= 0; i--) begin
            send(bits[i] ? 2'b10 : 2'b01, 4);
            send(2'b00, 4);
        end
    endtask

    task automatic send_end();
        send(2'b11, 4);
        send(2'b00, 4);
    endtask

    task automatic send_pattern(input int len, input logic [6:0] bits);
        send_syms(len, bits);
        send_end();
    endtask

    task automatic expect_char(input string tag, input logic [7:0] exp);
        logic [31:0] obs;
        obs = (got_q.size() > rd_idx) ? {24'd0, got_q[rd_idx]} : 32'hFFFF_FFFF;
        chk(tag, obs, {24'd0, exp});
        rd_idx++;
    endtask

    initial begin
        rst        = 1'b0;
        sym        = 2'b00;
        char_ready = 1'b0;
        tick(3);
        chk("rst_valid", {31'd0, char_valid}, 32'd0);
        chk("rst_data", {24'd0, char_data}, 32'h00);
        chk("rst_count", {29'd0, sym_count}, 32'd0);
        rst = 1'b1;
        tick(2);

        // Build a held E plus a half-built character, then reset.
        send_pattern(1, 7'h00);
        send_syms(2, 7'h00);
        chk("pre_rst_count", {29'd0, sym_count}, 32'd2);
        chk("pre_rst_valid", {31'd0, char_valid}, 32'd1);
        chk("pre_rst_data", {24'd0, char_data}, 32'h45);
        rst = 1'b0;
        tick(1);
        chk("mid_rst_valid", {31'd0, char_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, char_data}, 32'h00);
        chk("mid_rst_drop", {31'd0, char_drop}, 32'd0);
        chk("mid_rst_count", {29'd0, sym_count}, 32'd0);
        rst = 1'b1;
        rd_idx = got_q.size();
        char_ready = 1'b1;
        send(2'b11, 10);
        send(2'b00, 4);
        chk("lone_end_valid", {31'd0, char_valid}, 32'd0);
        chk("lone_end_none", got_q.size(), rd_idx);

        // Letter A with sym_count progression.
        send(2'b01, 4);
        chk("a_count1", {29'd0, sym_count}, 32'd1);
        send(2'b00, 4);
        send(2'b10, 4);
        chk("a_count2", {29'd0, sym_count}, 32'd2);
        send(2'b00, 4);
        send(2'b11, 4);
        chk("a_count0", {29'd0, sym_count}, 32'd0);
        send(2'b00, 4);
        expect_char("a_byte", 8'h41);
        chk("a_once", got_q.size(), rd_idx);

        // SOS, then a long held end-of-character.
        drop_base = drop_cnt;
        send_pattern(3, 7'h00);
        send_pattern(3, 7'h07);
        send_pattern(3, 7'h00);
        expect_char("sos_s1", 8'h53);
        expect_char("sos_o", 8'h4F);
        expect_char("sos_s2", 8'h53);
        chk("sos_nodrop", drop_cnt - drop_base, 32'd0);
        send(2'b11, 50);
        send(2'b00, 4);
        chk("hold_end_none", got_q.size(), rd_idx);

        // Digits, other letters, undefined and overflow patterns.
        send_pattern(5, 7'h1F);
        expect_char("digit_0", 8'h30);
        send_pattern(5, 7'h18);
        expect_char("digit_7", 8'h37);
        send_pattern(4, 7'h0D);
        expect_char("letter_q", 8'h51);
        send_pattern(2, 7'h03);
        expect_char("letter_m", 8'h4D);
        send_pattern(4, 7'h03);
        expect_char("undef_len4", 8'h3F);
        send_pattern(5, 7'h05);
        expect_char("undef_len5", 8'h3F);
        send_syms(6, 7'h00);
        chk("ovf_sat", {29'd0, sym_count}, 32'd5);
        send_end();
        expect_char("ovf_dots", 8'h3F);
        chk("ovf_clear", {29'd0, sym_count}, 32'd0);
        send_syms(6, 7'h15);
        chk("ovf_sat2", {29'd0, sym_count}, 32'd5);
        send_end();
        expect_char("ovf_mixed", 8'h3F);
        send_pattern(1, 7'h01);
        expect_char("after_ovf_t", 8'h54);

        // Backpressure: E held, T discarded with a single drop pulse.
        char_ready = 1'b0;
        drop_base = drop_cnt;
        send_pattern(1, 7'h00);
        chk("bp_valid_e", {31'd0, char_valid}, 32'd1);
        chk("bp_data_e", {24'd0, char_data}, 32'h45);
        send_pattern(1, 7'h01);
        chk("bp_valid_held", {31'd0, char_valid}, 32'd1);
        chk("bp_data_held", {24'd0, char_data}, 32'h45);
        chk("bp_drop_once", drop_cnt - drop_base, 32'd1);
        char_ready = 1'b1;
        tick(1);
        chk("bp_valid_drain", {31'd0, char_valid}, 32'd0);
        tick(4);
        expect_char("bp_accept_e", 8'h45);
        chk("bp_no_t", got_q.size(), rd_idx);

        // One-cycle glitch is never stable and produces no event.
        sym = 2'b01;
        tick(1);
        sym = 2'b00;
        tick(6);
        chk("glitch_count", {29'd0, sym_count}, 32'd0);

        // Clean dot: counted at edge t+2.
        sym = 2'b01;
        tick(1);
        chk("lat_t", {29'd0, sym_count}, 32'd0);
        tick(1);
        chk("lat_t1", {29'd0, sym_count}, 32'd0);
        tick(1);
        chk("lat_t2", {29'd0, sym_count}, 32'd1);
        send(2'b00, 4);

        // End code: char_valid rises after edge t+3.
        sym = 2'b11;
        tick(2);
        chk("end_t1_valid", {31'd0, char_valid}, 32'd0);
        tick(1);
        chk("end_t2_valid", {31'd0, char_valid}, 32'd0);
        chk("end_t2_count", {29'd0, sym_count}, 32'd0);
        tick(1);
        chk("end_t3_valid", {31'd0, char_valid}, 32'd1);
        chk("end_t3_data", {24'd0, char_data}, 32'h45);
        send(2'b00, 4);
        expect_char("lat_e", 8'h45);
        chk("lat_total", got_q.size(), rd_idx);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/morse_char_decoder.md
Name: morse_char_decoder

Overview:
- Sits directly downstream of the serial Morse symbol FSM and consumes its 2-bit symbol code: 00 none, 01 dot, 10 dash, 11 end-of-character.
- Accumulates dots and dashes, looks up the ITU Morse character at end-of-character, and presents one ASCII byte per character on a valid/ready port toward the LCD write controller.
- Runs on the system clock. The upstream symbol stream comes from the divided clock and is re-sampled here.

Parameters:
- MAX_SYMS, 5, maximum dot/dash count per character (3-bit length counter; legal range 1..7).
- UNKNOWN_CHAR, 8'h3F, byte emitted for an undecodable pattern or an overflow ('?').

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a clk edge resets the block).
- sym  input  2  upstream symbol code (00 idle, 01 dot, 10 dash, 11 end).
- char_data  output  8  decoded ASCII byte; valid only while char_valid is high.
- char_valid  output  1  char_data is available; held until accepted.
- char_ready  input  1  consumer accepts when char_valid && char_ready at a clk edge.
- char_drop  output  1  one-cycle pulse: a completed character was discarded because the output register was still full.
- sym_count  output  3  current accumulated symbol count (debug/LED).

Behaviour:
- Reset (rst==0 at an edge): char_valid=0, char_data=8'h00, char_drop=0, sym_count=0, pattern=0, overflow=0. Sampler and last-accepted registers are cleared to 00. Reset overrides all other activity, including a partially built character or a pending output.
- Input sampling:
  - Two-stage register: sym_q1 <= sym, then sym_q2 <= sym_q1.
  - A value counts as stable when sym_q1==sym_q2.
  - Event = stable && sym_q2 != last_sym && sym_q2 != 00. On every stable cycle, last_sym <= sym_q2.
  - One event per upstream symbol. A persistent 11 or any repeated stable value produces no further events. A 00 between symbols re-arms detection.
- Accumulator FSM, states IDLE (count 0), ACCUM, OVF:
  - Dot/dash event in IDLE or ACCUM: pattern <= {pattern[5:0], bit}, with dot=0 and dash=1 (first symbol ends up in the MSB of the length-count field). sym_count increments, and the state goes to ACCUM.
  - Dot/dash event when sym_count==MAX_SYMS: go to OVF. sym_count saturates at MAX_SYMS. Further dots/dashes are ignored.
  - End event in IDLE: ignored; no character is produced.
  - End event in ACCUM: look up (sym_count, pattern). End event in OVF: result is UNKNOWN_CHAR. In both cases clear pattern/sym_count and return to IDLE on the same edge.
- Lookup:
  - ITU International Morse, A–Z → 8'h41–8'h5A and 0–9 → 8'h30–8'h39.
  - Any other (length, pattern) → UNKNOWN_CHAR.
  - Combinational from the accumulator, then registered into char_data.
- Output register:
  - A lookup result is captured into char_data with char_valid=1 when the register is empty, or is being accepted on that same edge (char_valid && char_ready). Throughput is one char per cycle with no bubble.
  - If char_valid && !char_ready at the edge a lookup completes: keep the held byte unchanged, discard the new one, and pulse char_drop high for exactly one cycle.
  - char_valid && char_ready with no new lookup: char_valid=0. char_data holds its last value.
  - char_data must not change while char_valid && !char_ready.
- Latency: let t be the first edge at which sym_q1 captures a new code.
  - Accumulator update happens at edge t+2.
  - For an end code, char_valid goes high after edge t+3.
- Accumulation continues independently while the output is held.

Test Plan:
- Reset: drive rst=0 mid-character (sym_count=2, char_valid=1) → after one edge all outputs zero; a subsequent 11 alone produces no output.
- Letter A: sym 01,00,10,00,11, each held ≥4 clk (ready=1) → exactly one char_valid cycle with char_data=8'h41; sym_count goes 1,2,0.
- SOS: dot×3/end, dash×3/end, dot×3/end with ready=1 → bytes 8'h53, 8'h4F, 8'h53 in order, no char_drop. Then hold 11 for 50 clk → no extra char.
- Digit and overflow: five dashes + end → 8'h30. Six dots + end → 8'h3F, with sym_count saturating at 5. Undefined pattern dot-dash-dot-dash-dot-dash truncated to OVF → 8'h3F.
- Backpressure: ready=0, send E (dot,end) then T (dash,end) → char_data stays 8'h45 with valid high, and char_drop pulses once when T completes. Raise ready → 8'h45 accepted, valid drops, no T emitted.
- Latency and glitch: change sym for one clk only (never stable) → no event. A clean change is counted at edge t+2, and char_valid is observed after edge t+3.
